serial_byte_deser: RTL and testbench

- Downstream consumer of the 1-bit pattern waveform from the counter/memory/mux generator.
- Samples the serial line each enabled clock and hunts for a sync byte to find byte alignment.
- Once aligned, reassembles 8-bit bytes (LSB first, matching mux select order 0..7) and presents them on a valid/ready output.
- Monitors periodic sync slots and drops lock on repeated misses.

---
 rtl/serial_pkg.sv | 18 +
 rtl/serial_byte_deser_if.sv | 29 ++
 rtl/serial_byte_deser_byte_out_reg.sv | 62 ++++++
 rtl/serial_byte_deser.sv | 174 +++++++++++++++++
 tb/tb_serial_byte_deser.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// ----------------------------------------------------------------------------
// serial_pkg
//   Shared types and constants for the serial byte deserializer. BYTE_W and
//   SYNC_BYTE_DEFAULT are also used by the pattern generator's memory init, so
//   both ends of the link agree on the alignment byte.
//   Ports: none (package).
// ----------------------------------------------------------------------------
package serial_pkg;

   localparam int BYTE_W = 8;
   localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hCC;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } deser_state_e;

endpackage

// File: rtl/serial_byte_deser_if.sv
// ----------------------------------------------------------------------------
// serial_byte_deser_if
//   Valid/ready byte stream between the deserializer and its consumer.
//   Signals:
//     byte_data   assembled byte, bit 0 is the first bit received
//     byte_valid  byte_data holds an unconsumed byte
//     byte_ready  consumer accepts on byte_valid && byte_ready at a clk edge
//   Modports: master (deserializer side), slave (consumer side).
// ----------------------------------------------------------------------------
interface serial_byte_deser_if;
   import serial_pkg::*;

   logic [BYTE_W-1:0] byte_data;
   logic              byte_valid;
   logic              byte_ready;

   modport master (
      output byte_data,
      output byte_valid,
      input  byte_ready
   );

   modport slave (
      input  byte_data,
      input  byte_valid,
      output byte_ready
   );

endinterface

// File: rtl/serial_byte_deser_byte_out_reg.sv
// ----------------------------------------------------------------------------
// byte_out_reg
//   Single-entry valid/ready holding register. A byte offered while the
//   previous one is still pending and not being accepted is dropped and the
//   sticky overrun flag is raised; the held byte is never overwritten.
//   Ports:
//     clk          system clock, rising edge
//     clear        synchronous active-high reset
//     load_i       a completed byte is offered this cycle
//     load_data_i  the offered byte
//     overrun_o    sticky, a completed byte was dropped
//     out_if       master side of the byte stream
// ----------------------------------------------------------------------------
module byte_out_reg
   import serial_pkg::*;
(
   input  logic                       clk,
   input  logic                       clear,
   input  logic                       load_i,
   input  logic [BYTE_W-1:0]          load_data_i,
   output logic                       overrun_o,
   serial_byte_deser_if.master        out_if
);

   logic [BYTE_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              ovr_q, ovr_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (load_i) begin
         // Slot is free, or the pending byte leaves at this same edge.
         if (!valid_q || out_if.byte_ready) begin
            data_d  = load_data_i;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && out_if.byte_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign out_if.byte_data  = data_q;
   assign out_if.byte_valid = valid_q;
   assign overrun_o         = ovr_q;

endmodule

// File: rtl/serial_byte_deser.sv
// ----------------------------------------------------------------------------
// serial_byte_deser
//   Samples a 1-bit pattern waveform, hunts for SYNC_BYTE to find byte
//   alignment, then reassembles LSB-first bytes and presents them on a
//   valid/ready stream. Slot 0 of every SYNC_PERIOD-byte frame must carry
//   SYNC_BYTE; MISS_LIMIT consecutive misses drop lock.
//   Ports:
//     clk        system clock, rising edge
//     clear      synchronous active-high reset
//     serial_in  waveform bit
//     bit_en     sample qualifier, all state holds when 0
//     locked     1 while aligned
//     overrun    sticky, a completed byte was dropped
//     out_if     byte stream (byte_data / byte_valid / byte_ready)
//     err_count  only with SERIAL_BYTE_DESER_ERRCNT_EN defined: saturating
//                count of sync misses, overruns and lock losses
//   Build option: SERIAL_BYTE_DESER_ERRCNT_EN adds the err_count port/counter.
//
//   state  | meaning
//   HUNT   | unaligned, every enabled edge compares the last 8 bits to SYNC_BYTE
//   LOCKED | aligned, a byte completes every 8 enabled edges
// ----------------------------------------------------------------------------
module serial_byte_deser
   import serial_pkg::*;
#(
   parameter logic [BYTE_W-1:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
   parameter int unsigned       SYNC_PERIOD = 2,
   parameter int unsigned       MISS_LIMIT  = 2
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 serial_in,
   input  logic                 bit_en,
   output logic                 locked,
   output logic                 overrun,
   serial_byte_deser_if.master  out_if
`ifdef SERIAL_BYTE_DESER_ERRCNT_EN
   ,
   output logic [15:0]          err_count
`endif
);

   localparam int SLOT_W = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SYNC_PERIOD - 1);
   localparam logic [SLOT_W-1:0] SLOT_AFTER = SLOT_W'(1 % SYNC_PERIOD);
   localparam logic [2:0]        MISS_LIM   = 3'(MISS_LIMIT);

   deser_state_e      state_q, state_d;
   logic [BYTE_W-1:0] sr_q, sr_d, sr_next;
   // Down-counter of bits still to come in the current byte; 0 is the 8th bit.
   logic [2:0]        bits_left_q, bits_left_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [2:0]        miss_q, miss_d;
   logic              sync_hit;
   logic              complete;
   logic              sync_miss;
   logic              lock_loss;
   logic              deliver;

   assign sr_next  = {serial_in, sr_q[BYTE_W-1:1]};
   assign sync_hit = (sr_next == SYNC_BYTE);

   // State register
   always_ff @(posedge clk) begin
      if (clear) state_q <= HUNT;
      else       state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         HUNT:    if (bit_en && sync_hit) state_d = LOCKED;
         LOCKED:  if (lock_loss)          state_d = HUNT;
         default: state_d = HUNT;
      endcase
   end

   // Outputs of the FSM
   always_comb begin
      locked  = (state_q == LOCKED);
      deliver = complete && !lock_loss;
   end

   // Shift register, bit/slot/miss counters
   always_comb begin
      sr_d        = sr_q;
      bits_left_d = bits_left_q;
      slot_d      = slot_q;
      miss_d      = miss_q;
      complete    = 1'b0;
      sync_miss   = 1'b0;
      lock_loss   = 1'b0;
      if (bit_en) begin
         sr_d = sr_next;
         if (state_q == HUNT) begin
            if (sync_hit) begin
               // The sync byte itself is the first delivered byte (slot 0).
               complete    = 1'b1;
               bits_left_d = 3'd7;
               slot_d      = SLOT_AFTER;
               miss_d      = '0;
            end
         end else if (bits_left_q == 3'd0) begin
            complete    = 1'b1;
            bits_left_d = 3'd7;
            slot_d      = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
            if (slot_q == '0) begin
               if (sync_hit) begin
                  miss_d = '0;
               end else begin
                  sync_miss = 1'b1;
                  if (miss_q + 3'd1 == MISS_LIM) begin
                     lock_loss = 1'b1;
                     miss_d    = '0;
                     slot_d    = '0;
                  end else begin
                     miss_d = miss_q + 3'd1;
                  end
               end
            end
         end else begin
            bits_left_d = bits_left_q - 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         sr_q        <= '0;
         bits_left_q <= 3'd7;
         slot_q      <= '0;
         miss_q      <= '0;
      end else begin
         sr_q        <= sr_d;
         bits_left_q <= bits_left_d;
         slot_q      <= slot_d;
         miss_q      <= miss_d;
      end
   end

   byte_out_reg u_out (
      .clk         (clk),
      .clear       (clear),
      .load_i      (deliver),
      .load_data_i (sr_next),
      .overrun_o   (overrun),
      .out_if      (out_if)
   );

`ifdef SERIAL_BYTE_DESER_ERRCNT_EN
   logic [15:0] err_q, err_d;
   logic        ovr_evt;
   logic [1:0]  err_inc;
   logic [16:0] err_sum;

   // Lock loss never delivers, so at most two events coincide in one cycle.
   assign ovr_evt = deliver && out_if.byte_valid && !out_if.byte_ready;

   always_comb begin
      err_inc = {1'b0, sync_miss} + {1'b0, lock_loss} + {1'b0, ovr_evt};
      err_sum = {1'b0, err_q} + 17'(err_inc);
      err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

   always_ff @(posedge clk) begin
      if (clear) err_q <= '0;
      else       err_q <= err_d;
   end

   assign err_count = err_q;
`endif

endmodule

// File: tb/tb_serial_byte_deser.sv
module tb_serial_byte_deser;
   import serial_pkg::*;

   localparam logic [7:0] SYNC = 8'hCC;
   localparam int SP = 2;
   localparam int ML = 2;

   logic clk = 1'b0;
   logic clear, serial_in, bit_en;
   logic locked, overrun;
`ifdef SERIAL_BYTE_DESER_ERRCNT_EN
   logic [15:0] err_count;
`endif

   serial_byte_deser_if bus ();

   serial_byte_deser #(
      .SYNC_BYTE   (SYNC),
      .SYNC_PERIOD (SP),
      .MISS_LIMIT  (ML)
   ) dut (
      .clk       (clk),
      .clear     (clear),
      .serial_in (serial_in),
      .bit_en    (bit_en),
      .locked    (locked),
      .overrun   (overrun),
      .out_if    (bus)
`ifdef SERIAL_BYTE_DESER_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: keeps the last 8 received bits (oldest first), the
   // number of bits gathered since alignment and the byte index since lock.
   int m_hist[8];
   bit m_locked;
   int m_pos, m_idx, m_miss;
   bit m_valid, m_ovr;
   int m_data, m_err;

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   function automatic int hist_val();
      int v = 0;
      for (int i = 0; i < 8; i++) v += m_hist[i] * (1 << i);
      return v;
   endfunction

   task automatic model_step(input bit clr, input bit sin, input bit en, input bit rdy);
      bit done;
      int v;
      done = 1'b0;
      if (clr) begin
         for (int i = 0; i < 8; i++) m_hist[i] = 0;
         m_locked = 0; m_pos = 0; m_idx = 0; m_miss = 0;
         m_valid = 0; m_ovr = 0; m_data = 0; m_err = 0;
         return;
      end
      if (en) begin
         for (int i = 0; i < 7; i++) m_hist[i] = m_hist[i+1];
         m_hist[7] = int'(sin);
         v = hist_val();
         if (!m_locked) begin
            if (v == int'(SYNC)) begin
               m_locked = 1; m_pos = 0; m_idx = 1; m_miss = 0; done = 1;
            end
         end else begin
            m_pos++;
            if (m_pos == 8) begin
               m_pos = 0;
               done = 1;
               if (m_idx % SP == 0) begin
                  if (v == int'(SYNC)) m_miss = 0;
                  else begin
                     m_miss++;
                     m_err = sat16(m_err + 1);
                     if (m_miss == ML) begin
                        m_locked = 0;
                        m_err = sat16(m_err + 1);
                        done = 0;
                     end
                  end
               end
               m_idx++;
            end
         end
      end
      if (done) begin
         if (!m_valid || rdy) begin
            m_data = v;
            m_valid = 1;
         end else begin
            m_ovr = 1;
            m_err = sat16(m_err + 1);
         end
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
   endtask

   bit         collect = 0;
   logic [7:0] got[$];

   task automatic step(input bit clr, input bit sin, input bit en, input bit rdy);
      clear = clr; serial_in = sin; bit_en = en; bus.byte_ready = rdy;
      @(posedge clk);
      model_step(clr, sin, en, rdy);
      #1;
      chk("model_valid", bus.byte_valid, m_valid);
      chk("model_data", bus.byte_data, m_data);
      chk("model_locked", locked, m_locked);
      chk("model_overrun", overrun, m_ovr);
`ifdef SERIAL_BYTE_DESER_ERRCNT_EN
      chk("model_err_count", err_count, m_err);
`endif
      if (collect && bus.byte_valid) got.push_back(bus.byte_data);
   endtask

   task automatic do_clear();
      step(1, 0, 1, 1);
      step(1, 0, 1, 1);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit rdy);
      for (int i = 0; i < 8; i++) step(0, b[i], 1, rdy);
   endtask

   typedef struct {
      bit         clr, sin, en, rdy;
      bit         ev;
      logic [7:0] ed;
      bit         el, eo;
   } vec_t;

   vec_t tbl[20];

   logic [7:0] cc = 8'hCC;
   logic [7:0] aa = 8'hAA;
   logic [7:0] x0f = 8'h0F;

   initial begin
      int lock_at, n;
      bit lead[3];
      bit bq[$];
      logic [7:0] b;
      int slot_gen;
      bit clr, en, rdy, sin;

      // Reset, lock on CC, AA delivery, then hold with bit_en=0 / ready=0.
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hCC, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hCC, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hCC, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hCC, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hCC, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hCC, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hCC, 1'b1, 1'b0};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hCC, 1'b1, 1'b0};
      tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0};
      tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0};

      for (int i = 0; i < 20; i++) begin
         step(tbl[i].clr, tbl[i].sin, tbl[i].en, tbl[i].rdy);
         chk($sformatf("tbl%0d_valid", i), bus.byte_valid, tbl[i].ev);
         chk($sformatf("tbl%0d_data", i), bus.byte_data, tbl[i].ed);
         chk($sformatf("tbl%0d_locked", i), locked, tbl[i].el);
         chk($sformatf("tbl%0d_overrun", i), overrun, tbl[i].eo);
      end

      // Lock: CC,AA stream, each byte valid for exactly one cycle.
      do_clear();
      got.delete(); collect = 1;
      for (int k = 0; k < 3; k++) begin
         send_byte(cc, 1);
         send_byte(aa, 1);
      end
      collect = 0;
      chk("lock_byte_count", got.size(), 6);
      for (int i = 0; i < got.size(); i++)
         chk($sformatf("lock_byte%0d", i), got[i], (i % 2 == 1) ? 8'hAA : 8'hCC);
      chk("lock_overrun", overrun, 0);

      // Misalignment: 1,0,1 then CC locks on the 11th bit.
      do_clear();
      got.delete(); collect = 1;
      lead = '{1'b1, 1'b0, 1'b1};
      lock_at = 0; n = 0;
      for (int i = 0; i < 3; i++) begin
         step(0, lead[i], 1, 1); n++;
         if (locked && lock_at == 0) lock_at = n;
      end
      for (int i = 0; i < 8; i++) begin
         step(0, cc[i], 1, 1); n++;
         if (locked && lock_at == 0) lock_at = n;
      end
      collect = 0;
      chk("misalign_lock_bit", lock_at, 11);
      chk("misalign_bytes", got.size(), 1);
      if (got.size() > 0) chk("misalign_first", got[0], 8'hCC);

      // Lock loss: two sync slots carry 0F.
      do_clear();
      got.delete(); collect = 1;
      send_byte(cc, 1);
      send_byte(aa, 1);
      send_byte(x0f, 1);
      chk("loss_first_valid", bus.byte_valid, 1);
      chk("loss_first_data", bus.byte_data, 8'h0F);
      chk("loss_first_locked", locked, 1);
      send_byte(aa, 1);
      send_byte(x0f, 1);
      chk("loss_second_locked", locked, 0);
      chk("loss_second_valid", bus.byte_valid, 0);
      chk("loss_no_deliver", got.size(), 4);
      send_byte(cc, 1);
      chk("loss_relock", locked, 1);
      chk("loss_relock_data", bus.byte_data, 8'hCC);
      collect = 0;

      // Backpressure: ready low for 20 clks.
      do_clear();
      send_byte(cc, 1);
      for (int i = 0; i < 20; i++) begin
         b = (i < 8) ? aa : ((i < 16) ? cc : aa);
         step(0, b[i % 8], 1, 0);
         chk("bp_hold_data", bus.byte_data, 8'hCC);
      end
      chk("bp_valid", bus.byte_valid, 1);
      chk("bp_overrun", overrun, 1);
      step(0, aa[4], 1, 1);
      chk("bp_accept", bus.byte_valid, 0);
      for (int i = 5; i < 8; i++) step(0, aa[i], 1, 1);
      chk("bp_next_valid", bus.byte_valid, 1);
      chk("bp_next_data", bus.byte_data, 8'hAA);
      chk("bp_overrun_sticky", overrun, 1);

      // Reset mid-operation at bit 4 of an AA byte.
      do_clear();
      send_byte(cc, 1);
      send_byte(aa, 1);
      send_byte(cc, 1);
      for (int i = 0; i < 4; i++) step(0, aa[i], 1, 1);
      step(1, aa[4], 1, 1);
      chk("rst_valid", bus.byte_valid, 0);
      chk("rst_data", bus.byte_data, 8'h00);
      chk("rst_locked", locked, 0);
      chk("rst_overrun", overrun, 0);
      for (int i = 5; i < 8; i++) step(0, aa[i], 1, 1);
      for (int i = 0; i < 7; i++) step(0, cc[i], 1, 1);
      chk("rst_no_early_lock", locked, 0);
      step(0, cc[7], 1, 1);
      chk("rst_relock", locked, 1);
      chk("rst_relock_data", bus.byte_data, 8'hCC);

      // bit_en gating at half rate.
      do_clear();
      got.delete(); collect = 1;
      for (int k = 0; k < 4; k++) begin
         b = (k % 2 == 1) ? aa : cc;
         for (int i = 0; i < 8; i++) begin
            step(0, b[i], 1, 1);
            step(0, 1'($urandom), 0, 1);
         end
      end
      collect = 0;
      chk("gate_byte_count", got.size(), 4);
      for (int i = 0; i < got.size(); i++)
         chk($sformatf("gate_byte%0d", i), got[i], (i % 2 == 1) ? 8'hAA : 8'hCC);

      // Randomized framed stream with slips, corrupt syncs, gaps and stalls.
      do_clear();
      slot_gen = 0;
      for (int c = 0; c < 3000; c++) begin
         if (bq.size() == 0) begin
            if ($urandom_range(0, 19) == 0)
               repeat ($urandom_range(1, 3)) bq.push_back(1'($urandom));
            b = (slot_gen == 0 && $urandom_range(0, 99) < 85) ? SYNC : 8'($urandom);
            for (int i = 0; i < 8; i++) bq.push_back(b[i]);
            slot_gen = (slot_gen + 1) % SP;
         end
         clr = ($urandom_range(0, 499) == 0);
         en  = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         sin = bq[0];
         if (en && !clr) void'(bq.pop_front());
         step(clr, sin, en, rdy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
